// File: rtl/conv3_wm_ctrl.sv
// Weight-memory sequencer for conv3: streams a weight load into RAM port A, then
// replays the stored words to the PE array for a configurable number of passes.
module conv3_wm_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 512,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH:0]   i_cfg_words,
  input  logic [15:0]           i_cfg_reps,
  input  logic                  i_load_start,
  input  logic                  i_rd_start,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  output logic [DATA_WIDTH-1:0] o_wt_data,
  output logic                  o_wt_valid,
  input  logic                  i_wt_ready,
  output logic                  o_wt_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ram_wea,
  output logic [ADDR_WIDTH-1:0] o_ram_addra,
  output logic [DATA_WIDTH-1:0] o_ram_dina,
  output logic [ADDR_WIDTH-1:0] o_ram_addrb,
  input  logic [DATA_WIDTH-1:0] i_ram_doutb
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH:0]   r_wcnt;
  logic [ADDR_WIDTH:0]   r_rcnt;
  logic [15:0]           r_reps;
  logic [15:0]           r_pass;
  logic [RD_LATENCY-1:0] r_sr_valid;
  logic [RD_LATENCY-1:0] r_sr_last;
  logic [INF_W-1:0]      r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_fifo_cnt;

  logic [ADDR_WIDTH:0] w_words_m1;
  logic w_ld_fire, w_ld_last, w_rd_zero, w_credit, w_issue, w_rd_last;
  logic w_final_issue, w_push, w_pop;

  assign w_words_m1    = r_words - (ADDR_WIDTH+1)'(1);
  assign w_ld_fire     = o_ld_ready && i_ld_valid;
  assign w_ld_last     = w_ld_fire && (r_wcnt == w_words_m1);
  assign w_rd_zero     = (r_words == '0) || (r_reps == '0);
  // Every issued read already owns a FIFO slot, so the skid FIFO cannot overflow.
  assign w_credit      = (int'(r_fifo_cnt) + int'(r_inflight)) < FIFO_DEPTH;
  assign w_issue       = (r_state == S_READ) && !w_rd_zero && w_credit;
  assign w_rd_last     = (r_rcnt == w_words_m1);
  assign w_final_issue = w_issue && w_rd_last && (r_pass == r_reps - 16'd1);
  assign w_push        = r_sr_valid[RD_LATENCY-1];
  assign w_pop         = o_wt_valid && i_wt_ready;

  assign o_ld_ready  = (r_state == S_LOAD) && (r_words != '0);
  assign o_ram_wea   = w_ld_fire;
  assign o_ram_addra = r_wcnt[ADDR_WIDTH-1:0];
  assign o_ram_dina  = i_ld_data;
  assign o_ram_addrb = r_rcnt[ADDR_WIDTH-1:0];
  assign o_wt_valid  = (r_fifo_cnt != '0);
  assign o_wt_data   = o_wt_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign o_wt_last   = o_wt_valid && r_fifo_last[r_rd_ptr];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = ((r_state == S_LOAD) && ((r_words == '0) || w_ld_last)) ||
                       ((r_state == S_READ) && w_rd_zero) ||
                       ((r_state == S_DRAIN) && (r_inflight == '0) &&
                        (r_fifo_cnt == CNT_W'(1)) && w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_words <= '0;
      r_reps  <= '0;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_pass  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            r_state <= S_LOAD;
            r_words <= i_cfg_words;
            r_wcnt  <= '0;
          end else if (i_rd_start) begin
            r_state <= S_READ;
            r_words <= i_cfg_words;
            r_reps  <= i_cfg_reps;
            r_rcnt  <= '0;
            r_pass  <= '0;
          end
        end
        S_LOAD: begin
          if (w_ld_fire) r_wcnt <= r_wcnt + (ADDR_WIDTH+1)'(1);
          if ((r_words == '0) || w_ld_last) r_state <= S_IDLE;
        end
        S_READ: begin
          if (w_rd_zero) begin
            r_state <= S_IDLE;
          end else if (w_issue) begin
            if (w_rd_last) begin
              r_rcnt <= '0;
              r_pass <= r_pass + 16'd1;
            end else begin
              r_rcnt <= r_rcnt + (ADDR_WIDTH+1)'(1);
            end
            if (w_final_issue) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (o_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-latency tracker plus skid-FIFO bookkeeping; payload storage is unreset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr_valid <= '0;
      r_sr_last  <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      r_sr_valid[0] <= w_issue;
      r_sr_last[0]  <= w_rd_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sr_valid[i] <= r_sr_valid[i-1];
        r_sr_last[i]  <= r_sr_last[i-1];
      end
      r_inflight <= r_inflight + INF_W'(w_issue) - INF_W'(w_push);
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= i_ram_doutb;
      r_fifo_last[r_wr_ptr] <= r_sr_last[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_conv3_wm_ctrl.sv
// Bench for conv3_wm_ctrl: behavioural RAM, random weights and wt_ready, and a
// queue-based reference of the expected replay stream built from what was loaded.
module tb_conv3_wm_ctrl;

  localparam int AW  = 10;
  localparam int DW  = 512;
  localparam int RDL = 2;
  localparam int FD  = 4;

  logic          clk;
  logic          rst;
  logic [AW:0]   cfgWords;
  logic [15:0]   cfgReps;
  logic          loadStart, rdStart;
  logic [DW-1:0] ldData;
  logic          ldValid, ldReady;
  logic [DW-1:0] wtData;
  logic          wtValid, wtReady, wtLast;
  logic          busy, done;
  logic          wea;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, doutb;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] refMem [1<<AW];
  logic [DW-1:0] ramMem [1<<AW];
  logic [DW-1:0] ramPipe;

  conv3_wm_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_words(cfgWords), .i_cfg_reps(cfgReps),
    .i_load_start(loadStart), .i_rd_start(rdStart),
    .i_ld_data(ldData), .i_ld_valid(ldValid), .o_ld_ready(ldReady),
    .o_wt_data(wtData), .o_wt_valid(wtValid), .i_wt_ready(wtReady),
    .o_wt_last(wtLast), .o_busy(busy), .o_done(done),
    .o_ram_wea(wea), .o_ram_addra(addra), .o_ram_dina(dina),
    .o_ram_addrb(addrb), .i_ram_doutb(doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple-dual-port RAM with two registered read stages.
  always @(posedge clk) begin
    if (wea) ramMem[addra] <= dina;
    ramPipe <= ramMem[addrb];
    doutb   <= ramPipe;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string pfx);
    checkBit({pfx, "_busy"}, busy, 1'b0);
    checkBit({pfx, "_done"}, done, 1'b0);
    checkBit({pfx, "_wt_valid"}, wtValid, 1'b0);
    checkBit({pfx, "_wt_last"}, wtLast, 1'b0);
    checkBit({pfx, "_ld_ready"}, ldReady, 1'b0);
    checkBit({pfx, "_wea"}, wea, 1'b0);
    checkInt({pfx, "_addra"}, int'(addra), 0);
    checkInt({pfx, "_addrb"}, int'(addrb), 0);
    checkOutput({pfx, "_wt_data"}, wtData, '0);
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Drives one start cycle (cycle 0) and confirms the block was idle when it arrived.
  task automatic applyStimulus(input bit ls, input bit rs, input int words, input int reps);
    cfgWords  = (AW+1)'(words);
    cfgReps   = 16'(reps);
    loadStart = ls;
    rdStart   = rs;
    @(negedge clk);
    checkBit("start_idle_busy", busy, 1'b0);
    checkBit("start_idle_ld_ready", ldReady, 1'b0);
    @(posedge clk); #1;
    loadStart = 1'b0;
    rdStart   = 1'b0;
  endtask

  task automatic doLoad(input int words, input bit gapped, input bit fixedData,
                        input bit bothStart, input bit rdDuring);
    logic [DW-1:0] wd;
    int idx, cyc;
    bit fin;
    applyStimulus(1'b1, bothStart, words, 3);
    idx = 0; cyc = 1; fin = 1'b0;
    while (!fin && cyc < 4 * words + 20) begin
      wd      = fixedData ? DW'(32'hA0 + idx) : randWord();
      ldData  = wd;
      ldValid = (words == 0) ? 1'b1 : (!gapped || (cyc % 2 == 1));
      rdStart = rdDuring && (cyc == 2);
      @(negedge clk);
      if (words == 0) begin
        checkBit("ld_zero_done", done, 1'b1);
        checkBit("ld_zero_wea", wea, 1'b0);
        checkBit("ld_zero_ready", ldReady, 1'b0);
        fin = 1'b1;
      end else begin
        checkBit("ld_ready_load", ldReady, 1'b1);
        checkBit("ld_wea", wea, ldValid);
        if (ldValid) begin
          checkInt("ld_addra", int'(addra), idx);
          checkOutput("ld_dina", dina, wd);
          checkBit("ld_done", done, idx == words - 1);
          refMem[idx] = wd;
          if (idx == words - 1) fin = 1'b1;
          idx++;
        end else begin
          checkBit("ld_no_done", done, 1'b0);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    ldValid = 1'b0;
    rdStart = 1'b0;
    checkBit("ld_timeout", fin, 1'b1);
    @(negedge clk);
    checkBit("ld_busy_after", busy, 1'b0);
    checkBit("ld_ready_after", ldReady, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic doRead(input int words, input int reps, input bit randReady, input int abortAfter);
    logic [DW-1:0] expData[$];
    bit            expLast[$];
    logic [DW-1:0] ed;
    bit            el;
    logic [AW-1:0] prevAddrb;
    int cyc, got, issued, prevPopStart, firstValid, total;
    bit fin;
    total = words * reps;
    for (int p = 0; p < reps; p++)
      for (int i = 0; i < words; i++) begin
        expData.push_back(refMem[i]);
        expLast.push_back(i == words - 1);
      end
    wtReady = 1'b0;
    applyStimulus(1'b0, 1'b1, words, reps);
    cyc = 1; got = 0; issued = 0; prevPopStart = 0; firstValid = -1;
    fin = 1'b0; prevAddrb = '0;
    while (!fin && cyc < 8 * total + 40) begin
      wtReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (cyc == 1) checkBit("rd_busy_start", busy, 1'b1);
      if (total == 0) begin
        checkBit("rd_zero_done", done, 1'b1);
        checkBit("rd_zero_valid", wtValid, 1'b0);
        fin = 1'b1;
      end else begin
        if (!randReady && cyc <= total)
          checkInt("rd_addrb_seq", int'(addrb), (cyc - 1) % words);
        // An address step means a read was issued last cycle; words issued minus
        // words consumed is what the FIFO plus the read pipe must hold.
        if (words > 1 && cyc >= 2 && addrb != prevAddrb) begin
          checkBit("rd_credit", (issued - prevPopStart) < FD, 1'b1);
          issued++;
        end
        prevAddrb    = addrb;
        prevPopStart = got;
        if (wtValid && firstValid < 0) begin
          firstValid = cyc;
          checkInt("rd_first_valid", firstValid, RDL + 2);
        end
        if (wtValid && wtReady) begin
          if (expData.size() == 0) begin
            checkInt("rd_word_count", got + 1, total);
          end else begin
            ed = expData.pop_front();
            el = expLast.pop_front();
            got++;
            checkOutput("rd_data", wtData, ed);
            checkBit("rd_last", wtLast, el);
            checkBit("rd_done", done, got == total);
            if (got == total) begin
              fin = 1'b1;
              if (!randReady) checkInt("rd_done_cycle", cyc, total + RDL + 1);
              if (words > 1) checkInt("rd_issue_count", issued, total);
            end
            if (abortAfter > 0 && got == abortAfter) fin = 1'b1;
          end
        end else begin
          checkBit("rd_no_done", done, 1'b0);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checkBit("rd_timeout", fin, 1'b1);
    if (abortAfter == 0) begin
      wtReady = 1'b0;
      @(negedge clk);
      checkBit("rd_busy_after", busy, 1'b0);
      checkBit("rd_valid_after", wtValid, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    cfgWords = '0; cfgReps = '0; loadStart = 1'b0; rdStart = 1'b0;
    ldData = '0; ldValid = 1'b0; wtReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("rst_init");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] gapped load of A0..A3");
    doLoad(4, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] read 4x2 with wt_ready high");
    doRead(4, 2, 1'b0, 0);

    $display("[TB] read 4x2 with random wt_ready");
    doRead(4, 2, 1'b1, 0);

    $display("[TB] reset after three words, then fresh read");
    doRead(4, 2, 1'b0, 3);
    #2 rst = 1'b1;
    #1 checkReset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    doRead(4, 1, 1'b0, 0);

    $display("[TB] simultaneous starts and rd_start during load");
    doLoad(2, 1'b0, 1'b0, 1'b1, 1'b1);
    doRead(2, 3, 1'b1, 0);

    $display("[TB] full-depth load and read");
    doLoad(1024, 1'b0, 1'b0, 1'b0, 1'b0);
    doRead(1024, 1, 1'b0, 0);

    $display("[TB] zero configurations");
    doLoad(0, 1'b0, 1'b0, 1'b0, 1'b0);
    doRead(0, 2, 1'b0, 0);
    doRead(4, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
